div_result_buffer: RTL and testbench
====================================

// Module: div_result_buffer
// PURPOSE
//  - Downstream stage of the 2-bit combinational divider. Registers each {a,b,quotient,remainder}
//    result into a DEPTH-entry FIFO and presents it on a valid/ready output port.
//  - Handles divide-by-zero, replaces unknown upstream bits with defined values, and keeps
//    saturating statistics counters. Sits between the divider and the result consumer.
// PARAMETERS
//  - W      2  operand/result width (a, b, quotient, remainder)
//  - DEPTH  4  FIFO entries; power of two, >=2
//  - CNT_W  8  width of statistics counters
// PORTS
//  - clk            in   1          single clock, rising edge
//  - rst_n          in   1          asynchronous active-low reset
//  - in_valid       in   1          upstream result valid
//  - in_ready       out  1          block can accept (= !full)
//  - in_a           in   W          dividend presented to divider
//  - in_b           in   W          divisor presented to divider
//  - in_quotient    in   W          divider quotient
//  - in_remainder   in   W          divider remainder
//  - out_valid      out  1          FIFO head valid (= !empty)
//  - out_ready      in   1          consumer accepts head
//  - out_quotient   out  W          head quotient
//  - out_remainder  out  W          head remainder
//  - out_dbz        out  1          head entry was divide-by-zero
//  - out_err        out  1          head entry failed self-check (0 without macro)
//  - level          out  log2(DEPTH)+1  current occupancy
//  - res_cnt        out  CNT_W      accepted results, saturating
//  - dbz_cnt        out  CNT_W      accepted divide-by-zero results, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): rd/wr pointers=0, level=0, out_valid=0, out_quotient=0,
//    out_remainder=0, out_dbz=0, out_err=0, res_cnt=0, dbz_cnt=0. in_ready=1 one cycle after release.
//  - Push on in_valid&&in_ready; pop on out_valid&&out_ready; both in the same cycle are legal.
//  - Latency: pushed entry is visible at the head on the next edge (no combinational bypass).
//  - Full: in_ready=0 even when out_ready=1 (no pass-through). A push attempt is ignored and never
//    counted. Empty: pop has no effect; out_* data holds its last value and out_valid=0.
//  - Simultaneous push+pop: level unchanged; both pointers advance; wrap modulo DEPTH.
//  - Divide-by-zero (in_b==0): stored quotient={W{1'b1}}, remainder=in_a, dbz=1. Divider outputs ignored.
//  - Unknown sanitisation (in_b!=0): any X/Z bit in in_quotient/in_remainder is stored as 0.
//    Sanitisation uses case-equality and applies in simulation only; synthesis passes data through.
//  - res_cnt += 1 per push; dbz_cnt += 1 per dbz push; both hold at 2^CNT_W-1.
//  - Output registers are assigned from the head entry; there is no FSM beyond the pointer/level logic.
//  - Reset asserted mid-stream discards all entries immediately; counters clear.
// CONFIGURATION
//  - DIV_RESULT_CHECK_EN defined: each non-dbz push recomputes q=a/b, r=a%b internally.
//    err=1 is stored if the sanitised divider result differs. out_err reflects the head entry.
//    A saturating err_cnt (CNT_W) is added and exposed as output err_cnt.
//  - DIV_RESULT_CHECK_EN undefined: no checker logic; out_err is tied to 0; no err_cnt port.
// STRUCTURE
//  - Package div_pkg: localparams W_DEF=2, DBZ_QUOTIENT='1; typedef div_entry_t
//    {quotient, remainder, dbz, err}.
//  - Sub-module div_fifo_core: a generic DEPTH x $bits(div_entry_t) storage array with
//    pointers and level. The top level holds sanitisation, dbz, checker and counters.
// TESTING
//  - Reset: push 3 entries, then drop rst_n -> level=0, out_valid=0, counters=0 asynchronously.
//  - a=3,b=2,q=1,r=1, out_ready=1 -> next cycle out_valid=1, q=1, r=1, dbz=0, res_cnt=1.
//  - a=2,b=0 with divider q=2'bxx -> q=2'b11, r=2'b10, dbz=1, dbz_cnt=1.
//  - out_ready=0, push 5 -> in_ready=0 after 4; 5th push ignored; level=4; res_cnt=4; drain order is FIFO.
//  - Full, then in_valid=1 and out_ready=1 for 1 cycle -> pop only, level=3; 6 push/pop cycles wrap pointers, data in order.
//  - CHECK_EN: a=3,b=1, divider q=2,r=0 -> out_err=1, err_cnt=1; correct q=3 -> out_err=0.
//  - 300 pushes with b=0 -> res_cnt=dbz_cnt=255 (saturated).

Source files
------------

// File: rtl/div_result_buffer_pkg.sv
// Package div_pkg: shared constants and the stored entry type of the
// divider result buffer.
//   W_DEF        default operand/result width
//   DBZ_QUOTIENT quotient stored for a divide-by-zero result (all ones)
//   div_entry_t  one FIFO entry {quotient, remainder, dbz, err}
package div_pkg;

  localparam int W_DEF = 2;
  localparam logic [W_DEF-1:0] DBZ_QUOTIENT = '1;

  typedef struct packed {
    logic [W_DEF-1:0] quotient;
    logic [W_DEF-1:0] remainder;
    logic             dbz;
    logic             err;
  } div_entry_t;

endpackage

// File: rtl/div_result_buffer_if.sv
// Interface div_result_buffer_if: upstream (divider -> buffer) and downstream
// (buffer -> consumer) valid/ready ports of the result buffer.
//   in_valid/in_ready, in_a, in_b, in_quotient, in_remainder  upstream side
//   out_valid/out_ready, out_quotient, out_remainder,
//   out_dbz, out_err                                          downstream side
// Modports: master = the environment around the buffer, slave = the buffer.
interface div_result_buffer_if #(
  parameter int W = 2
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_quotient;
  logic [W-1:0] in_remainder;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         out_dbz;
  logic         out_err;

  modport master (
    output in_valid, in_a, in_b, in_quotient, in_remainder, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_dbz, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_quotient, in_remainder, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_dbz, out_err
  );

endinterface

// File: rtl/div_result_buffer_fifo.sv
// Module div_fifo_core: generic DEPTH x DW FIFO with a registered head.
//   clk, rst_n   clock / asynchronous active-low reset
//   push, pop    requests; push ignored when full, pop ignored when empty
//   wr_data      data written on an accepted push
//   full, empty  occupancy flags
//   level        current occupancy (0..DEPTH)
//   head_data    registered copy of the oldest entry; holds when empty
// DEPTH must be a power of two so the pointers wrap naturally.
module div_fifo_core #(
  parameter int DEPTH = 4,
  parameter int DW    = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [DW-1:0]          head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [AW:0]   level_q, remain, level_next;
  logic [DW-1:0] head_q, head_next;
  logic          push_ok, pop_ok;

  assign full      = (level_q == (AW+1)'(DEPTH));
  assign empty     = (level_q == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign level     = level_q;
  assign head_data = head_q;

  // Next head: the oldest entry left in storage after the pop, or the
  // entry being written right now when storage would otherwise be empty.
  always_comb begin
    rd_next    = rd_ptr + AW'(pop_ok);
    remain     = level_q - (AW+1)'(pop_ok);
    level_next = remain + (AW+1)'(push_ok);
    head_next  = head_q;
    if (remain != '0)
      head_next = mem[rd_next];
    else if (push_ok)
      head_next = wr_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      rd_ptr  <= rd_next;
      wr_ptr  <= wr_ptr + AW'(push_ok);
      level_q <= level_next;
      head_q  <= head_next;
    end
  end

endmodule

// File: rtl/div_result_buffer.sv
// Module div_result_buffer: buffers results of the 2-bit divider in a FIFO
// and presents them on a valid/ready port.
//   clk, rst_n        clock / asynchronous active-low reset
//   bus (slave)       upstream and downstream handshakes, see div_result_buffer_if
//   level             FIFO occupancy
//   res_cnt, dbz_cnt  saturating counts of accepted / divide-by-zero results
//   err_cnt           saturating count of self-check failures (macro only)
// Optional feature: define DIV_RESULT_CHECK_EN to recompute a/b and a%b for
// every non-dbz push and flag divider results that disagree.
module div_result_buffer
  import div_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  div_result_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       res_cnt,
`ifdef DIV_RESULT_CHECK_EN
  output logic [CNT_W-1:0]       err_cnt,
`endif
  output logic [CNT_W-1:0]       dbz_cnt
);

  div_entry_t   wr_entry, head_entry;
  logic [W-1:0] q_clean, r_clean;
  logic         full, empty, push_ok, is_dbz;

  assign is_dbz  = (bus.in_b == '0);
  assign push_ok = bus.in_valid && !full;

  // Undriven or unknown divider bits become 0 in simulation; hardware has
  // no X, so synthesis sees a plain pass-through.
`ifdef SYNTHESIS
  assign q_clean = bus.in_quotient;
  assign r_clean = bus.in_remainder;
`else
  always_comb begin
    q_clean = '0;
    r_clean = '0;
    for (int i = 0; i < W; i++) begin
      q_clean[i] = (bus.in_quotient[i] === 1'b1);
      r_clean[i] = (bus.in_remainder[i] === 1'b1);
    end
  end
`endif

`ifdef DIV_RESULT_CHECK_EN
  logic [W-1:0] exp_q, exp_r;
  assign exp_q = bus.in_a / bus.in_b;
  assign exp_r = bus.in_a % bus.in_b;
`endif

  // Divide-by-zero ignores the divider outputs entirely.
  always_comb begin
    wr_entry = '0;
    if (is_dbz) begin
      wr_entry.quotient  = DBZ_QUOTIENT;
      wr_entry.remainder = bus.in_a;
      wr_entry.dbz       = 1'b1;
    end else begin
      wr_entry.quotient  = q_clean;
      wr_entry.remainder = r_clean;
`ifdef DIV_RESULT_CHECK_EN
      wr_entry.err       = (q_clean != exp_q) || (r_clean != exp_r);
`endif
    end
  end

  div_fifo_core #(
    .DEPTH (DEPTH),
    .DW    ($bits(div_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.in_valid),
    .pop       (bus.out_ready),
    .wr_data   (wr_entry),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .head_data (head_entry)
  );

  // Full blocks the upstream even if the consumer pops this cycle.
  assign bus.in_ready      = !full;
  assign bus.out_valid     = !empty;
  assign bus.out_quotient  = head_entry.quotient;
  assign bus.out_remainder = head_entry.remainder;
  assign bus.out_dbz       = head_entry.dbz;
  // err is only ever written as 1 by the checker, so this is 0 without it.
  assign bus.out_err       = head_entry.err;

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
      dbz_cnt <= '0;
    end else if (push_ok) begin
      if (res_cnt != '1)
        res_cnt <= res_cnt + 1'b1;
      if (is_dbz && dbz_cnt != '1)
        dbz_cnt <= dbz_cnt + 1'b1;
    end
  end

`ifdef DIV_RESULT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (push_ok && wr_entry.err && err_cnt != '1)
      err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_div_result_buffer.sv
// Testbench for div_result_buffer: directed vectors, a queue-based reference
// model compared against the DUT on every falling clock edge, and literal
// hand-computed expectations at key points. Honours DIV_RESULT_CHECK_EN.
module tb_div_result_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] level;
  logic [7:0] res_cnt, dbz_cnt;
`ifdef DIV_RESULT_CHECK_EN
  logic [7:0] err_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  div_result_buffer_if #(.W(2)) bus ();

  div_result_buffer #(.W(2), .DEPTH(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .level   (level),
    .res_cnt (res_cnt),
`ifdef DIV_RESULT_CHECK_EN
    .err_cnt (err_cnt),
`endif
    .dbz_cnt (dbz_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of expected entries plus counters.
  typedef struct {
    logic [1:0] q;
    logic [1:0] r;
    logic       dbz;
    logic       err;
  } m_entry_t;

  m_entry_t   mq[$];
  m_entry_t   m_new;
  logic [1:0] m_last_q = '0;
  logic [1:0] m_last_r = '0;
  logic       m_last_dbz = 1'b0;
  logic       m_last_err = 1'b0;
  int         m_res = 0;
  int         m_dbz = 0;
  int         m_err = 0;
  bit         m_push, m_pop;

  function automatic logic [1:0] clean(input logic [1:0] v);
    logic [1:0] res;
    for (int i = 0; i < 2; i++)
      res[i] = (v[i] === 1'b1);
    return res;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last_q   = '0;
      m_last_r   = '0;
      m_last_dbz = 1'b0;
      m_last_err = 1'b0;
      m_res      = 0;
      m_dbz      = 0;
      m_err      = 0;
    end else begin
      m_push = bus.in_valid && (mq.size() < 4);
      m_pop  = bus.out_ready && (mq.size() > 0);
      if (m_pop)
        void'(mq.pop_front());
      if (m_push) begin
        if (bus.in_b == 2'd0) begin
          m_new.q   = 2'b11;
          m_new.r   = bus.in_a;
          m_new.dbz = 1'b1;
          m_new.err = 1'b0;
        end else begin
          m_new.q   = clean(bus.in_quotient);
          m_new.r   = clean(bus.in_remainder);
          m_new.dbz = 1'b0;
`ifdef DIV_RESULT_CHECK_EN
          m_new.err = (m_new.q != bus.in_a / bus.in_b) || (m_new.r != bus.in_a % bus.in_b);
`else
          m_new.err = 1'b0;
`endif
        end
        mq.push_back(m_new);
        if (m_res < 255) m_res++;
        if (m_new.dbz && m_dbz < 255) m_dbz++;
        if (m_new.err && m_err < 255) m_err++;
      end
      if (mq.size() > 0) begin
        m_last_q   = mq[0].q;
        m_last_r   = mq[0].r;
        m_last_dbz = mq[0].dbz;
        m_last_err = mq[0].err;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] q, input logic [1:0] r, input logic rdy);
    bus.in_valid     = v;
    bus.in_a         = a;
    bus.in_b         = b;
    bus.in_quotient  = q;
    bus.in_remainder = r;
    bus.out_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    checkOutput("in_ready", int'(bus.in_ready), int'(mq.size() < 4));
    checkOutput("out_valid", int'(bus.out_valid), int'(mq.size() > 0));
    checkOutput("level", int'(level), mq.size());
    checkOutput("out_quotient", int'(bus.out_quotient), int'(m_last_q));
    checkOutput("out_remainder", int'(bus.out_remainder), int'(m_last_r));
    checkOutput("out_dbz", int'(bus.out_dbz), int'(m_last_dbz));
    checkOutput("out_err", int'(bus.out_err), int'(m_last_err));
    checkOutput("res_cnt", int'(res_cnt), m_res);
    checkOutput("dbz_cnt", int'(dbz_cnt), m_dbz);
`ifdef DIV_RESULT_CHECK_EN
    checkOutput("err_cnt", int'(err_cnt), m_err);
`endif
  end

  initial begin
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_a         = '0;
    bus.in_b         = '0;
    bus.in_quotient  = '0;
    bus.in_remainder = '0;
    bus.out_ready    = 1'b0;

    // Reset values
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("rst_out_quotient", int'(bus.out_quotient), 0);
    checkOutput("rst_res_cnt", int'(res_cnt), 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_in_ready", int'(bus.in_ready), 1);

    // Three pushes, then an asynchronous reset mid-stream
    applyStimulus(1, 1, 1, 1, 0, 0);
    applyStimulus(1, 2, 1, 2, 0, 0);
    applyStimulus(1, 3, 1, 3, 0, 0);
    checkOutput("pre_rst_level", int'(level), 3);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_level", int'(level), 0);
    checkOutput("async_rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("async_rst_res_cnt", int'(res_cnt), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Single result: 3/2 = 1 rem 1, visible one edge after the push
    applyStimulus(1, 3, 2, 1, 1, 1);
    checkOutput("single_valid", int'(bus.out_valid), 1);
    checkOutput("single_q", int'(bus.out_quotient), 1);
    checkOutput("single_r", int'(bus.out_remainder), 1);
    checkOutput("single_dbz", int'(bus.out_dbz), 0);
    checkOutput("single_res_cnt", int'(res_cnt), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("empty_hold_q", int'(bus.out_quotient), 1);

    // Divide by zero with unknown divider quotient
    applyStimulus(1, 2, 0, 2'bxx, 0, 0);
    checkOutput("dbz_q", int'(bus.out_quotient), 3);
    checkOutput("dbz_r", int'(bus.out_remainder), 2);
    checkOutput("dbz_flag", int'(bus.out_dbz), 1);
    checkOutput("dbz_cnt_1", int'(dbz_cnt), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Fill with out_ready low; fifth push must be ignored
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 0);
    applyStimulus(1, 2, 1, 2, 0, 0);
    applyStimulus(1, 3, 1, 3, 0, 0);
    checkOutput("full_in_ready", int'(bus.in_ready), 0);
    checkOutput("full_level", int'(level), 4);
    applyStimulus(1, 3, 3, 1, 0, 0);
    checkOutput("full_level_after_5th", int'(level), 4);
    checkOutput("full_res_cnt", int'(res_cnt), 6);
    checkOutput("full_head_q", int'(bus.out_quotient), 0);

    // Full with push and pop requested: pop only
    applyStimulus(1, 2, 2, 1, 0, 1);
    checkOutput("full_pop_level", int'(level), 3);
    checkOutput("full_pop_res_cnt", int'(res_cnt), 6);
    checkOutput("full_pop_head_q", int'(bus.out_quotient), 1);

    // Six simultaneous push/pop cycles wrap the pointers
    for (int i = 0; i < 6; i++) begin
      logic [1:0] a, b;
      a = 2'((i + 1) % 4);
      b = 2'((i % 3) + 1);
      applyStimulus(1, a, b, a / b, a % b, 1);
    end
    checkOutput("wrap_level", int'(level), 3);
    checkOutput("wrap_res_cnt", int'(res_cnt), 12);

    // Drain
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("drain_out_valid", int'(bus.out_valid), 0);

`ifdef DIV_RESULT_CHECK_EN
    // Self-check: 3/1 reported as 2 rem 0 is wrong, 3 rem 0 is right
    applyStimulus(1, 3, 1, 2, 0, 0);
    checkOutput("chk_err_1", int'(bus.out_err), 1);
    checkOutput("chk_err_cnt", int'(err_cnt), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 3, 1, 3, 0, 0);
    checkOutput("chk_err_0", int'(bus.out_err), 0);
    checkOutput("chk_err_cnt_hold", int'(err_cnt), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
`endif

    // Counter saturation with 300 divide-by-zero pushes
    for (int i = 0; i < 300; i++)
      applyStimulus(1, 2'(i % 4), 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("sat_res_cnt", int'(res_cnt), 255);
    checkOutput("sat_dbz_cnt", int'(dbz_cnt), 255);
    checkOutput("sat_out_valid", int'(bus.out_valid), 0);

    applyStimulus(0, 0, 0, 0, 0, 0);
    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
